// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: program counter, ROM address drive and IF/ID pipeline register.
// Optional build macro FETCH_MISALIGN_TRAP_EN traps misaligned redirects to TRAP_PC.
module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter logic [31:0] TRAP_PC   = 32'h0000_0100
) (
  input  logic        CLK,
  input  logic        RST_n,
  input  logic        STALL,
  input  logic        FLUSH,
  input  logic        REDIRECT_EN,
  input  logic [31:0] REDIRECT_PC,
  output logic [31:0] INS_ADDRESS,
  input  logic [31:0] INSTRUCTION_IN,
  output logic [31:0] IF_ID_PC,
  output logic [31:0] IF_ID_PC4,
  output logic [31:0] IF_ID_INSTR,
  output logic        IF_ID_VALID,
  output logic [31:0] FETCH_COUNT,
  output logic        MISALIGN
);

  localparam int unsigned XLEN = 32;
  localparam logic ST_BOOT = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  logic            state_q,     state_d;
  logic [XLEN-1:0] pc_q,        pc_d;
  logic [XLEN-1:0] if_pc_q,     if_pc_d;
  logic [XLEN-1:0] if_pc4_q,    if_pc4_d;
  logic [XLEN-1:0] if_instr_q,  if_instr_d;
  logic            if_valid_q,  if_valid_d;
  logic [XLEN-1:0] fetch_cnt_q, fetch_cnt_d;
  logic [XLEN-1:0] pc_plus4_c;
  logic [XLEN-1:0] redir_pc_c;

  assign pc_plus4_c = pc_q + XLEN'(4);

`ifdef FETCH_MISALIGN_TRAP_EN
  logic redir_mis_c;
  logic misalign_q, misalign_d;

  // Misaligned targets are diverted to the trap vector and flagged.
  always_comb begin
    redir_mis_c = 1'b0;
    redir_pc_c  = {REDIRECT_PC[XLEN-1:2], 2'b00};
    if (REDIRECT_PC[1:0] != 2'b00) begin
      redir_pc_c  = TRAP_PC;
      redir_mis_c = 1'b1;
    end
  end

  assign MISALIGN = misalign_q;
`else
  logic unused_redir_lsb;

  // Misaligned targets are silently word-aligned.
  assign redir_pc_c       = {REDIRECT_PC[XLEN-1:2], 2'b00};
  assign unused_redir_lsb = ^{REDIRECT_PC[1:0], TRAP_PC};
  assign MISALIGN         = 1'b0;
`endif

  // Next-state logic: REDIRECT_EN > FLUSH > STALL > normal fetch.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    if_pc_d     = if_pc_q;
    if_pc4_d    = if_pc4_q;
    if_instr_d  = if_instr_q;
    if_valid_d  = if_valid_q;
    fetch_cnt_d = fetch_cnt_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    misalign_d  = 1'b0;
`endif

    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
        if (REDIRECT_EN) begin
          pc_d = redir_pc_c;
`ifdef FETCH_MISALIGN_TRAP_EN
          misalign_d = redir_mis_c;
`endif
        end
      end
      default: begin
        state_d = ST_RUN;
        if (REDIRECT_EN) begin
          pc_d       = redir_pc_c;
          if_instr_d = NOP_INSTR;
          if_valid_d = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
          misalign_d = redir_mis_c;
`endif
        end else if (FLUSH) begin
          if_instr_d = NOP_INSTR;
          if_valid_d = 1'b0;
          if (!STALL) begin
            pc_d = pc_plus4_c;
          end
        end else if (!STALL) begin
          pc_d        = pc_plus4_c;
          if_pc_d     = pc_q;
          if_pc4_d    = pc_plus4_c;
          if_instr_d  = INSTRUCTION_IN;
          if_valid_d  = 1'b1;
          fetch_cnt_d = fetch_cnt_q + XLEN'(1);
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q     <= ST_BOOT;
      pc_q        <= RESET_PC;
      if_pc_q     <= '0;
      if_pc4_q    <= '0;
      if_instr_q  <= NOP_INSTR;
      if_valid_q  <= 1'b0;
      fetch_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      if_pc_q     <= if_pc_d;
      if_pc4_q    <= if_pc4_d;
      if_instr_q  <= if_instr_d;
      if_valid_q  <= if_valid_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end
`endif

  assign INS_ADDRESS = pc_q;
  assign IF_ID_PC    = if_pc_q;
  assign IF_ID_PC4   = if_pc4_q;
  assign IF_ID_INSTR = if_instr_q;
  assign IF_ID_VALID = if_valid_q;
  assign FETCH_COUNT = fetch_cnt_q;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Scoreboard bench for instr_fetch_stage: directed steps push expected state, a negedge monitor compares.
module tb_instr_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCH_MISALIGN_TRAP_EN
  localparam logic [31:0] MIS_TGT = 32'h0000_0100;
  localparam logic        MIS_EXP = 1'b1;
`else
  localparam logic [31:0] MIS_TGT = 32'h0000_0040;
  localparam logic        MIS_EXP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0, flush = 1'b0, redir = 1'b0;
  logic [31:0] redir_pc = '0;
  logic [31:0] ins_addr, ins_in, if_pc, if_pc4, if_instr, fetch_cnt;
  logic        if_valid, misalign;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        valid;
    logic [31:0] cnt;
    logic        mis;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  // Fibonacci program in the low words; distinct filler elsewhere.
  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h00: rom = 32'h0000_0093;
      32'h04: rom = 32'h0010_0113;
      32'h08: rom = 32'h00a0_0193;
      32'h0C: rom = 32'h0020_8233;
      32'h10: rom = 32'h0001_0093;
      32'h14: rom = 32'h0002_0113;
      32'h18: rom = 32'hfff1_8193;
      32'h1C: rom = 32'hfe01_96e3;
      32'h20: rom = 32'h0020_2023;
      32'h24: rom = 32'h0000_006f;
      default: rom = {a[23:0], 8'h33};
    endcase
  endfunction

  assign ins_in = rom(ins_addr);

  instr_fetch_stage dut (
    .CLK(clk), .RST_n(rst_n), .STALL(stall), .FLUSH(flush),
    .REDIRECT_EN(redir), .REDIRECT_PC(redir_pc), .INS_ADDRESS(ins_addr),
    .INSTRUCTION_IN(ins_in), .IF_ID_PC(if_pc), .IF_ID_PC4(if_pc4),
    .IF_ID_INSTR(if_instr), .IF_ID_VALID(if_valid), .FETCH_COUNT(fetch_cnt),
    .MISALIGN(misalign)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d actual=%08h required=%08h", name, c, act, exp);
  endtask

  // Monitor: compare every queued expectation due this cycle.
  initial begin
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("ins_address", e.cyc, ins_addr, e.addr);
        chk("if_id_pc", e.cyc, if_pc, e.pc);
        chk("if_id_pc4", e.cyc, if_pc4, e.pc4);
        chk("if_id_instr", e.cyc, if_instr, e.instr);
        chk("if_id_valid", e.cyc, 32'(if_valid), 32'(e.valid));
        chk("fetch_count", e.cyc, fetch_cnt, e.cnt);
        chk("misalign", e.cyc, 32'(misalign), 32'(e.mis));
      end
    end
  end

  task automatic push(input logic [31:0] addr, input logic [31:0] pc, input logic [31:0] pc4,
                      input logic valid, input logic [31:0] cnt, input logic mis);
    exp_t e;
    e.cyc = cyc; e.addr = addr; e.pc = pc; e.pc4 = pc4;
    e.instr = valid ? rom(pc) : NOP;
    e.valid = valid; e.cnt = cnt; e.mis = mis;
    exp_q.push_back(e);
  endtask

  // Apply inputs for one edge, then queue the state expected after it.
  task automatic step(input logic s, input logic f, input logic r, input logic [31:0] rpc,
                      input logic [31:0] addr, input logic [31:0] pc, input logic [31:0] pc4,
                      input logic valid, input logic [31:0] cnt, input logic mis);
    stall = s; flush = f; redir = r; redir_pc = rpc;
    @(posedge clk);
    #1;
    stall = 1'b0; flush = 1'b0; redir = 1'b0; redir_pc = '0;
    push(addr, pc, pc4, valid, cnt, mis);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 push(32'h0, 32'h0, 32'h0, 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Boot bubble, then first capture of RESET_PC
    step(0, 0, 0, 0, 32'h00, 32'h00, 32'h00, 1'b0, 32'd0, 1'b0);
    step(0, 0, 0, 0, 32'h04, 32'h00, 32'h04, 1'b1, 32'd1, 1'b0);
    for (int i = 1; i < 10; i++)
      step(0, 0, 0, 0, 32'(4 * (i + 1)), 32'(4 * i), 32'(4 * i + 4), 1'b1, 32'(i + 1), 1'b0);

    // Back to 0x08, run to pc_q=0x10, then stall three cycles
    step(0, 0, 1, 32'h08, 32'h08, 32'h24, 32'h28, 1'b0, 32'd10, 1'b0);
    step(0, 0, 0, 0, 32'h0C, 32'h08, 32'h0C, 1'b1, 32'd11, 1'b0);
    step(0, 0, 0, 0, 32'h10, 32'h0C, 32'h10, 1'b1, 32'd12, 1'b0);
    for (int i = 0; i < 3; i++)
      step(1, 0, 0, 0, 32'h10, 32'h0C, 32'h10, 1'b1, 32'd12, 1'b0);
    step(0, 0, 0, 0, 32'h14, 32'h10, 32'h14, 1'b1, 32'd13, 1'b0);

    // Redirect wins over flush and stall
    step(1, 1, 1, 32'h40, 32'h40, 32'h10, 32'h14, 1'b0, 32'd13, 1'b0);
    step(0, 0, 0, 0, 32'h44, 32'h40, 32'h44, 1'b1, 32'd14, 1'b0);

    // Flush alone advances PC; flush with stall holds it
    step(0, 1, 0, 0, 32'h48, 32'h40, 32'h44, 1'b0, 32'd14, 1'b0);
    step(1, 1, 0, 0, 32'h48, 32'h40, 32'h44, 1'b0, 32'd14, 1'b0);
    step(0, 0, 0, 0, 32'h4C, 32'h48, 32'h4C, 1'b1, 32'd15, 1'b0);

    // Misaligned redirect
    step(0, 0, 1, 32'h42, MIS_TGT, 32'h48, 32'h4C, 1'b0, 32'd15, MIS_EXP);
    step(0, 0, 0, 0, MIS_TGT + 32'h4, MIS_TGT, MIS_TGT + 32'h4, 1'b1, 32'd16, 1'b0);

    // PC wrap at the top of the address space
    step(0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, MIS_TGT, MIS_TGT + 32'h4, 1'b0, 32'd16, 1'b0);
    step(0, 0, 0, 0, 32'h0, 32'hFFFF_FFFC, 32'h0, 1'b1, 32'd17, 1'b0);
    step(0, 0, 0, 0, 32'h4, 32'h0, 32'h4, 1'b1, 32'd18, 1'b0);

    // Async reset between edges, checked before any further clock edge
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 push(32'h0, 32'h0, 32'h0, 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    step(0, 0, 0, 0, 32'h00, 32'h00, 32'h00, 1'b0, 32'd0, 1'b0);
    step(0, 0, 0, 0, 32'h04, 32'h00, 32'h04, 1'b1, 32'd1, 1'b0);

    @(negedge clk);
    #1;
    n_chk++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain actual=%0d pending required=0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
